// File: rtl/vram_pkg.sv
// vram_pkg
//   Shared definitions for the VRAM writer slice: default SRAM address/data
//   widths, strobe timer width, the writer FSM state encoding, and a helper
//   that turns a phase length in cycles into a down-counter load value.
package vram_pkg;

  localparam int VRAM_AWIDTH = 19;
  localparam int VRAM_DWIDTH = 8;
  localparam int TIMER_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_VERIFY = 3'd5
  } vramState_e;

  // A phase of N cycles finishes when the counter reaches zero, so load N-1.
  function automatic logic [TIMER_W-1:0] phaseLoad(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/vram_strobe_timer.sv
// vram_strobe_timer
//   Loadable down-counter that times the SETUP and STROBE phases of an SRAM
//   write. Load has priority; otherwise the count decrements until zero and
//   holds there.
// Ports:
//   Clk      in   system clock (posedge)
//   ResetN   in   asynchronous active-low reset
//   Load     in   load LoadVal this cycle
//   LoadVal  in   TIMER_W-bit load value (phase length - 1)
//   Done     out  count is zero (current phase ends this cycle)
module vram_strobe_timer
  import vram_pkg::*;
(
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Load,
  input  logic [TIMER_W-1:0] LoadVal,
  output logic               Done
);

  logic [TIMER_W-1:0] count_r;

  // Down-counter with load; saturates at zero.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (Load) begin
      count_r <= LoadVal;
    end else if (count_r != {TIMER_W{1'b0}}) begin
      count_r <= count_r - TIMER_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign Done = (count_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/vram_writer.sv
// vram_writer
//   Drains the byte-command decoder's address/data FIFO into the external
//   async SRAM framebuffer and arbitrates the SRAM bus with video scanout.
//   Scanout wins in IDLE, but a write that has started always runs to
//   completion before scanout gets the bus.
//   Optional feature macro: VRAM_WRITE_VERIFY_EN adds a read-back VERIFY
//   cycle after every write and a sticky VerifyErr output.
// Ports:
//   Clk, ResetN            clock, asynchronous active-low reset
//   HasReadData/AddrIn/DataIn  FIFO head (valid while HasReadData)
//   ReadOutClk             one-cycle FIFO pop pulse
//   ScanReq/ScanAddr       scanout request and read address
//   ScanGrant/ScanData     scanout owns bus / registered read data
//   SramAddr/SramDataOut/SramDataOe/SramDataIn/SramWeN/SramOeN  SRAM pins
//   VerifyErr              (VRAM_WRITE_VERIFY_EN only) sticky read-back error
module vram_writer
  import vram_pkg::*;
#(
  parameter int AWIDTH   = VRAM_AWIDTH,
  parameter int DWIDTH   = VRAM_DWIDTH,
  parameter int WE_SETUP = 1,
  parameter int WE_PULSE = 2
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              HasReadData,
  input  logic [AWIDTH-1:0] AddrIn,
  input  logic [DWIDTH-1:0] DataIn,
  output logic              ReadOutClk,
  input  logic              ScanReq,
  input  logic [AWIDTH-1:0] ScanAddr,
  output logic              ScanGrant,
  output logic [DWIDTH-1:0] ScanData,
  output logic [AWIDTH-1:0] SramAddr,
  output logic [DWIDTH-1:0] SramDataOut,
  output logic              SramDataOe,
  input  logic [DWIDTH-1:0] SramDataIn,
  output logic              SramWeN,
  output logic              SramOeN
`ifdef VRAM_WRITE_VERIFY_EN
  ,
  output logic              VerifyErr
`endif
);

  vramState_e         state_r;
  logic [AWIDTH-1:0]  addr_r;
  logic               timerLoad_s;
  logic [TIMER_W-1:0] timerVal_s;
  logic               timerDone_s;

  // Scanout drives the address straight through so a read needs no extra cycle.
  assign SramAddr = (state_r == ST_SCAN) ? ScanAddr : addr_r;

  // Timer load: start SETUP timing when a write is accepted, STROBE timing when SETUP ends.
  always_comb begin
    timerLoad_s = 1'b0;
    timerVal_s  = {TIMER_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (!ScanReq && HasReadData) begin
          timerLoad_s = 1'b1;
          timerVal_s  = phaseLoad(WE_SETUP);
        end else begin
          timerLoad_s = 1'b0;
        end
      end
      ST_SETUP: begin
        if (timerDone_s) begin
          timerLoad_s = 1'b1;
          timerVal_s  = phaseLoad(WE_PULSE);
        end else begin
          timerLoad_s = 1'b0;
        end
      end
      default: begin
        timerLoad_s = 1'b0;
      end
    endcase
  end

  vram_strobe_timer uTimer (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .Load    (timerLoad_s),
    .LoadVal (timerVal_s),
    .Done    (timerDone_s)
  );

  // Writer/arbiter FSM with all bus controls registered alongside the state.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r     <= ST_IDLE;
      addr_r      <= {AWIDTH{1'b0}};
      ReadOutClk  <= 1'b0;
      ScanGrant   <= 1'b0;
      ScanData    <= {DWIDTH{1'b0}};
      SramDataOut <= {DWIDTH{1'b0}};
      SramDataOe  <= 1'b0;
      SramWeN     <= 1'b1;
      SramOeN     <= 1'b1;
`ifdef VRAM_WRITE_VERIFY_EN
      VerifyErr   <= 1'b0;
`endif
    end else begin
      // Pop pulse lasts exactly one cycle; only the IDLE->SETUP branch raises it.
      ReadOutClk <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ScanReq) begin
            state_r    <= ST_SCAN;
            ScanGrant  <= 1'b1;
            SramOeN    <= 1'b0;
            SramDataOe <= 1'b0;
          end else if (HasReadData) begin
            // Head is captured here and popped, so it is never read twice.
            state_r     <= ST_SETUP;
            addr_r      <= AddrIn;
            SramDataOut <= DataIn;
            ReadOutClk  <= 1'b1;
            SramDataOe  <= 1'b1;
            SramOeN     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          ScanData <= SramDataIn;
          if (!ScanReq) begin
            state_r   <= ST_IDLE;
            ScanGrant <= 1'b0;
            SramOeN   <= 1'b1;
          end else begin
            state_r <= ST_SCAN;
          end
        end
        ST_SETUP: begin
          if (timerDone_s) begin
            state_r <= ST_STROBE;
            SramWeN <= 1'b0;
          end else begin
            state_r <= ST_SETUP;
          end
        end
        ST_STROBE: begin
          if (timerDone_s) begin
            state_r <= ST_HOLD;
            SramWeN <= 1'b1;
          end else begin
            state_r <= ST_STROBE;
          end
        end
        ST_HOLD: begin
          SramDataOe <= 1'b0;
`ifdef VRAM_WRITE_VERIFY_EN
          // Read the byte back at the same address on the next cycle.
          state_r <= ST_VERIFY;
          SramOeN <= 1'b0;
`else
          state_r <= ST_IDLE;
`endif
        end
        ST_VERIFY: begin
`ifdef VRAM_WRITE_VERIFY_EN
          if (SramDataIn != SramDataOut) begin
            VerifyErr <= 1'b1;
          end else begin
            VerifyErr <= VerifyErr;
          end
          SramOeN <= 1'b1;
`endif
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          ScanGrant  <= 1'b0;
          SramDataOe <= 1'b0;
          SramWeN    <= 1'b1;
          SramOeN    <= 1'b1;
        end
      endcase
    end
  end

endmodule
